// File: rtl/fir_tb_pkg.sv
// Shared types and default sizes for the FIR response capture block.
package fir_tb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 32;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_SKIP,
        CAP_CAPTURE,
        CAP_DONE
    } cap_state_t;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_response_capture_ram.sv
// Capture buffer: one write port, one registered read port, no reset on the array.
// A read and a write to the same address in one cycle return the old word.
module capture_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Write and registered read share the edge, giving read-before-write.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fir_response_capture.sv
// Captures a window of FIR output samples after an optional skip, tracking signed
// min/max, and exposes the buffer through a one-cycle-latency read port.
module fir_response_capture
    import fir_tb_pkg::*;
#(
    parameter int unsigned DATA_W = fir_tb_pkg::DATA_W,
    parameter int unsigned DEPTH  = fir_tb_pkg::DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned SKIP   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned SKIP_W = 8;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam cap_state_t        ARM_STATE = (SKIP > 0) ? CAP_SKIP : CAP_CAPTURE;

    cap_state_t                r_state;
    cap_state_t                w_next_state;
    logic [SKIP_W-1:0]         r_skip_cnt;
    logic [CNT_W-1:0]          r_count;
    logic                      r_done;
    logic                      r_busy;
    logic signed [DATA_W-1:0]  r_min;
    logic signed [DATA_W-1:0]  r_max;
    logic                      r_rd_valid;
    logic                      r_rd_loaded;
    logic                      w_clear;
    logic                      w_skip_inc;
    logic                      w_wr_en;
    logic signed [DATA_W-1:0]  w_sample;
    logic [DATA_W-1:0]         w_ram_rd_data;

    assign w_sample = $signed(in_data);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= CAP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control; start overrides everything and drops in_valid.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_skip_inc   = 1'b0;
        w_wr_en      = 1'b0;
        if (start) begin
            w_next_state = ARM_STATE;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                CAP_SKIP: begin
                    if (in_valid) begin
                        if (r_skip_cnt == SKIP_LAST) begin
                            w_next_state = CAP_CAPTURE;
                        end else begin
                            w_skip_inc = 1'b1;
                        end
                    end
                end
                CAP_CAPTURE: begin
                    if (in_valid) begin
                        w_wr_en = 1'b1;
                        if (r_count == CNT_LAST) begin
                            w_next_state = CAP_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Skip/write counters and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_skip_cnt <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= (w_next_state == CAP_SKIP) || (w_next_state == CAP_CAPTURE);
            if (w_clear) begin
                r_skip_cnt <= '0;
                r_count    <= '0;
                r_done     <= 1'b0;
            end else begin
                if (w_skip_inc) begin
                    r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
                end
                if (w_wr_en) begin
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_LAST) begin
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Signed min/max; the first sample of a window reloads both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_min <= '0;
            r_max <= '0;
        end else if (w_wr_en) begin
            if (r_count == '0) begin
                r_min <= w_sample;
                r_max <= w_sample;
            end else begin
                if (w_sample < r_min) begin
                    r_min <= w_sample;
                end
                if (w_sample > r_max) begin
                    r_max <= w_sample;
                end
            end
        end
    end

    // Readback qualifiers; rd_data reads as zero until the first read after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_valid  <= 1'b0;
            r_rd_loaded <= 1'b0;
        end else begin
            r_rd_valid  <= rd_en;
            r_rd_loaded <= r_rd_loaded | rd_en;
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en & rst),
        .i_wr_addr (r_count[ADDR_W-1:0]),
        .i_wr_data (in_data),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_ram_rd_data)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign min_val  = r_min;
    assign max_val  = r_max;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_loaded ? w_ram_rd_data : '0;

endmodule

// File: tb/tb_fir_response_capture.sv
// Directed bench: one instance with SKIP=2, one with SKIP=0, sharing data and read inputs.
module tb_fir_response_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        start2;
    logic        start0;
    logic        in_valid;
    logic [15:0] in_data;
    logic        rd_en;
    logic [4:0]  rd_addr;

    logic        s2_busy, s2_done, s2_rd_valid;
    logic [5:0]  s2_count;
    logic [15:0] s2_min, s2_max, s2_rd_data;
    logic        s0_busy, s0_done, s0_rd_valid;
    logic [5:0]  s0_count;
    logic [15:0] s0_min, s0_max, s0_rd_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fir_response_capture #(.DATA_W(16), .DEPTH(32), .ADDR_W(5), .SKIP(2)) dut_s2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_data(in_data),
        .busy(s2_busy), .done(s2_done), .count(s2_count), .min_val(s2_min), .max_val(s2_max),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(s2_rd_data), .rd_valid(s2_rd_valid)
    );

    fir_response_capture #(.DATA_W(16), .DEPTH(32), .ADDR_W(5), .SKIP(0)) dut_s0 (
        .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .in_data(in_data),
        .busy(s0_busy), .done(s0_done), .count(s0_count), .min_val(s0_min), .max_val(s0_max),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(s0_rd_data), .rd_valid(s0_rd_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic feed(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start2 = 1'b1; else start0 = 1'b1;
        tick();
        start2 = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic readback(input bit sel, input int a, input logic [15:0] exp);
        rd_en   = 1'b1;
        rd_addr = 5'(a);
        tick();
        rd_en   = 1'b0;
        if (sel) begin
            check($sformatf("s2_rd_valid[%0d]", a), 32'(s2_rd_valid), 32'd1);
            check($sformatf("s2_rd_data[%0d]", a), 32'(s2_rd_data), 32'(exp));
        end else begin
            check($sformatf("s0_rd_valid[%0d]", a), 32'(s0_rd_valid), 32'd1);
            check($sformatf("s0_rd_data[%0d]", a), 32'(s0_rd_data), 32'(exp));
        end
    endtask

    initial begin
        int rises;
        logic prev;
        rst = 1'b0; start2 = 1'b0; start0 = 1'b0;
        in_valid = 1'b0; in_data = '0; rd_en = 1'b0; rd_addr = '0;
        idle(2);

        // Reset values
        check("rst_busy", 32'(s2_busy), 0);
        check("rst_done", 32'(s2_done), 0);
        check("rst_count", 32'(s2_count), 0);
        check("rst_min", 32'(s2_min), 0);
        check("rst_max", 32'(s2_max), 0);
        check("rst_rd_data", 32'(s2_rd_data), 0);
        check("rst_rd_valid", 32'(s2_rd_valid), 0);
        rst = 1'b1;
        tick();

        // Valids without start are ignored
        for (int i = 0; i < 10; i++) feed(16'h0055);
        check("t1_count2", 32'(s2_count), 0);
        check("t1_done2", 32'(s2_done), 0);
        check("t1_busy2", 32'(s2_busy), 0);
        check("t1_count0", 32'(s0_count), 0);
        check("t1_busy0", 32'(s0_busy), 0);

        // SKIP=2, continuous 0..33
        pulse_start(1'b1);
        check("t2_busy_armed", 32'(s2_busy), 1);
        check("t2_count_armed", 32'(s2_count), 0);
        for (int i = 0; i < 34; i++) begin
            feed(16'(i));
            if (i == 32) begin
                check("t2_count_pre", 32'(s2_count), 31);
                check("t2_done_pre", 32'(s2_done), 0);
            end
        end
        check("t2_done", 32'(s2_done), 1);
        check("t2_count", 32'(s2_count), 32);
        check("t2_busy", 32'(s2_busy), 0);
        check("t2_min", 32'(s2_min), 2);
        check("t2_max", 32'(s2_max), 33);
        for (int i = 0; i < 5; i++) feed(16'h1234);
        check("t2_count_hold", 32'(s2_count), 32);
        check("t2_done_hold", 32'(s2_done), 1);
        for (int a = 0; a < 32; a++) readback(1'b1, a, 16'(a + 2));
        tick();
        check("t2_rd_valid_low", 32'(s2_rd_valid), 0);
        check("t2_rd_data_hold", 32'(s2_rd_data), 33);

        // SKIP=0, in_valid every third cycle, 100..131
        pulse_start(1'b0);
        check("t4_busy_armed", 32'(s0_busy), 1);
        for (int i = 0; i < 32; i++) begin
            idle(2);
            check($sformatf("t4_busy_gap%0d", i), 32'(s0_busy), 1);
            feed(16'(100 + i));
        end
        check("t4_done", 32'(s0_done), 1);
        check("t4_count", 32'(s0_count), 32);
        check("t4_busy", 32'(s0_busy), 0);
        check("t4_min", 32'(s0_min), 100);
        check("t4_max", 32'(s0_max), 131);
        for (int a = 0; a < 32; a++) readback(1'b0, a, 16'(100 + a));

        // Signed extremes; min/max held across start until first sample
        pulse_start(1'b0);
        check("t3_min_held", 32'(s0_min), 100);
        check("t3_max_held", 32'(s0_max), 131);
        check("t3_done_clr", 32'(s0_done), 0);
        feed(16'h0005);
        feed(16'h8000);
        feed(16'h7FFF);
        for (int i = 0; i < 29; i++) feed(16'h0000);
        check("t3_done", 32'(s0_done), 1);
        check("t3_min", 32'(s0_min), 32'h8000);
        check("t3_max", 32'(s0_max), 32'h7FFF);
        readback(1'b0, 1, 16'h8000);
        readback(1'b0, 2, 16'h7FFF);

        // Restart after 10 samples; in_valid on the start cycle is dropped
        pulse_start(1'b0);
        for (int i = 0; i < 10; i++) feed(16'(200 + i));
        check("t5_count10", 32'(s0_count), 10);
        start0 = 1'b1; in_valid = 1'b1; in_data = 16'd999;
        tick();
        start0 = 1'b0; in_valid = 1'b0;
        check("t5_count_clr", 32'(s0_count), 0);
        check("t5_done_clr", 32'(s0_done), 0);
        check("t5_busy", 32'(s0_busy), 1);
        rises = 0;
        prev  = s0_done;
        for (int i = 0; i < 36; i++) begin
            feed((i < 32) ? 16'(300 + i) : 16'h0055);
            if (s0_done && !prev) rises++;
            prev = s0_done;
        end
        check("t5_done_rises", 32'(rises), 1);
        check("t5_count", 32'(s0_count), 32);
        check("t5_min", 32'(s0_min), 300);
        check("t5_max", 32'(s0_max), 331);
        readback(1'b0, 0, 16'd300);
        readback(1'b0, 9, 16'd309);
        readback(1'b0, 31, 16'd331);

        // Reset mid-capture
        pulse_start(1'b1);
        for (int i = 0; i < 7; i++) feed(16'(i));
        check("t6_count_pre", 32'(s2_count), 5);
        rst = 1'b0; in_valid = 1'b1; in_data = 16'd77;
        tick();
        rst = 1'b1; in_valid = 1'b0;
        check("t6_busy", 32'(s2_busy), 0);
        check("t6_done", 32'(s2_done), 0);
        check("t6_count", 32'(s2_count), 0);
        check("t6_min", 32'(s2_min), 0);
        check("t6_max", 32'(s2_max), 0);
        check("t6_rd_data", 32'(s2_rd_data), 0);
        check("t6_rd_valid", 32'(s2_rd_valid), 0);
        for (int i = 0; i < 5; i++) feed(16'h0099);
        check("t6_count_idle", 32'(s2_count), 0);
        check("t6_busy_idle", 32'(s2_busy), 0);
        readback(1'b1, 5, 16'd7);
        readback(1'b1, 0, 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
